fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-deep byte FIFO.
- Drains bytes from the FIFO one at a time, honouring the FIFO's one-cycle registered read latency.
- Serialises each byte onto a single UART-style line: 8N1, LSB first, idle-high.
- Sits between the FIFO read port and the board/testbench serial pin.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit (≥1; 4 for sim, set from clk/baud in synthesis).
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  permit starting new frames; a frame in progress always completes
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd is sampled
- fifo_rd  output  1  FIFO read strobe, registered, one-cycle pulse per byte
- tx  output  1  serial line, registered, idle high
- busy  output  1  high from the RD state through the end of STOP
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0.
  - Bit counter=0, bit index=0, shift register=0.
  - Reset overrides every other input.
- States: IDLE, RD, LATCH, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If en=1 and fifo_empty=0 at edge E0, go to RD; fifo_rd=1 during the following cycle.
  - Otherwise stay in IDLE.
- RD:
  - fifo_rd=1 for exactly this one cycle.
  - Next edge E1: go to LATCH, fifo_rd returns to 0.
  - The FIFO updates fifo_dout at E1.
- LATCH:
  - At E2: shift register <= fifo_dout, tx <= 0, counter <= 0, go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - When counter==CLKS_PER_BIT-1: counter<=0, bit index<=0, tx<=shreg[0], go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right, bit index+1, tx<=next bit.
  - After bit index 7 completes: tx<=1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle of STOP, then go to IDLE.
- Timing:
  - Frame on the line is exactly 10*CLKS_PER_BIT cycles.
  - First falling edge of tx appears 2 cycles after the IDLE edge that saw fifo_empty=0.
  - Back-to-back gap: minimum idle-high time between a stop bit and the next start bit is 3 cycles (IDLE, RD, LATCH).
- Handshake rules:
  - fifo_rd is never asserted unless fifo_empty was 0 at the deciding IDLE edge.
  - Exactly one fifo_rd pulse per transmitted frame.
  - This block is the FIFO's only reader.
- en:
  - Deasserting en mid-frame has no effect on the current frame.
  - Checked only in IDLE.
- Simultaneous events: an upstream write into an empty FIFO raises fifo_empty=0 one cycle later; this block reacts on the next IDLE edge. No combinational path from fifo_empty to fifo_rd.
- Reset mid-frame:
  - tx forced to 1 and state to IDLE at that edge.
  - The partially sent byte is dropped, not re-read.
  - A fifo_rd in flight is cancelled.
- Counter arithmetic: unsigned, compare-equal to CLKS_PER_BIT-1, no wrap beyond that.
- CLKS_PER_BIT=1: every bit lasts one cycle; all transitions still hold.

Test Plan:
- Reset: rst=1 for 3 cycles, fifo_empty=0, en=1 → tx=1, fifo_rd=0, busy=0, frame_done=0 throughout; first fifo_rd appears the cycle after rst falls +1.
- Single byte 0xA5, CLKS_PER_BIT=4 → one fifo_rd pulse; tx sampled per bit = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles; frame_done pulses once at cycle 40 of the frame.
- Back-to-back: FIFO preloaded with 0x00, 0xFF, 0x3C → three fifo_rd pulses; frames decoded as 0x00, 0xFF, 0x3C; exactly 3 idle-high cycles between a stop bit and the next start bit; busy low only in those IDLE cycles.
- Empty/enable: fifo_empty=1 for 50 cycles then en=0 with fifo_empty=0 → no fifo_rd, tx stays 1; raise en → frame starts 2 cycles later; drop en mid-DATA → frame completes and no further read occurs.
- Reset mid-frame: assert rst during DATA bit 3 of 0x5A → tx=1 at the next edge and no frame_done; after release with the FIFO still non-empty, the next byte (not 0x5A) is transmitted intact.
- CLKS_PER_BIT=1 with byte 0x81 → 10-cycle frame reading 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO with one-cycle read latency and
// serialises each byte as 8N1, LSB first, on an idle-high line.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             rd_q, rd_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state: frame sequencing, bit timing and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (en && !fifo_empty) begin
                    state_d = S_RD;
                    rd_d    = 1'b1;
                end
            end
            S_RD: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // fifo_dout became valid at the edge that left RD.
                shreg_d = fifo_dout;
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // shreg_q[0] is the bit on the line; [1] is next.
                        shreg_d = {1'b0, shreg_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset drops any partial frame and pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
        end
    end

    assign fifo_rd    = rd_q;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model plus line decoder for fifo_uart_tx.
// Expected bytes are queued on write and popped as frames decode.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en = 1'b0;
    logic en1 = 1'b0;

    logic empty, rd, tx, busy, fd;
    logic empty1, rd1, tx1, busy1, fd1;
    logic [7:0] dout, dout1;

    logic [7:0] mem [256];
    logic [7:0] mem1 [256];
    logic [7:0] wp = '0;
    logic [7:0] rp = '0;
    logic [7:0] wp1 = '0;
    logic [7:0] rp1 = '0;

    int tot = 0;
    int bad = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(empty),
        .fifo_dout(dout), .fifo_rd(rd), .tx(tx), .busy(busy),
        .frame_done(fd)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1),
        .fifo_dout(dout1), .fifo_rd(rd1), .tx(tx1), .busy(busy1),
        .frame_done(fd1)
    );

    assign empty  = (wp == rp);
    assign empty1 = (wp1 == rp1);

    // FIFO models: registered read data, one cycle after the strobe.
    always @(posedge clk) begin
        if (rd === 1'b1) begin
            tot++;
            if (wp == rp) begin
                bad++;
                $display("FAIL rd_on_empty got=rd=1 want=no read");
            end
            dout <= mem[rp];
            rp <= rp + 8'd1;
        end
        if (rd1 === 1'b1) begin
            dout1 <= mem1[rp1];
            rp1 <= rp1 + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (rd === 1'b1) rd_cnt++;
        if (fd === 1'b1) fd_cnt++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 8'd1;
        exp_q.push_back(b);
    endtask

    // Decode one frame from dut; gap counts idle-high samples first.
    task automatic rx(input int budget, output logic [9:0] bits,
                      output int gap, output int nb0, output bit held,
                      output bit bsy, output int fdp, output bit to);
        gap = 0; nb0 = 0; held = 1; bsy = 1; fdp = -1; to = 1;
        bits = '0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (tx === 1'b0) begin
                to = 0;
                break;
            end
            gap++;
            if (busy !== 1'b1) nb0++;
        end
        if (!to) begin
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < CPB; j++) begin
                    if (i != 0 || j != 0) tick();
                    if (j == 0) bits[i] = tx;
                    else if (tx !== bits[i]) held = 0;
                    if (busy !== 1'b1) bsy = 0;
                    if (fd === 1'b1) fdp = (fdp < 0) ? i * CPB + j : 999;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [9:0] bits; int gap, nb, fdp; bit held, bsy, to;
        logic [7:0] e;
        rst = 1; en = 1;
        push(8'hC3);
        for (int i = 0; i < 3; i++) begin
            tick();
            tot++;
            if ({tx, rd, busy, fd} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_out cyc=%0d got=%b want=1000",
                         i, {tx, rd, busy, fd});
            end
        end
        rst = 0;
        tick();
        tot++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_rd got=%b want=1", rd);
        end
        rx(50, bits, gap, nb, held, bsy, fdp, to);
        e = exp_q.pop_front();
        tot++;
        if (to || bits[8:1] !== e || !held) begin
            bad++;
            $display("FAIL reset_frame got=%h to=%0d want=%h",
                     bits[8:1], to, e);
        end
    endtask

    task automatic test_single;
        logic [9:0] bits; int gap, nb, fdp, rd0, fd0; bit held, bsy, to;
        logic [7:0] e;
        rd0 = rd_cnt; fd0 = fd_cnt;
        push(8'hA5);
        rx(50, bits, gap, nb, held, bsy, fdp, to);
        e = exp_q.pop_front();
        tot++;
        if (to || bits !== 10'b1101001010) begin
            bad++;
            $display("FAIL single_bits got=%b want=1101001010", bits);
        end
        tot++;
        if (bits[8:1] !== e || !held || !bsy) begin
            bad++;
            $display("FAIL single_byte got=%h held=%0d busy=%0d want=%h",
                     bits[8:1], held, bsy, e);
        end
        tot++;
        if (fdp != 39 || fd_cnt - fd0 != 1) begin
            bad++;
            $display("FAIL single_fd got=%0d/%0d want=39/1",
                     fdp, fd_cnt - fd0);
        end
        tot++;
        if (rd_cnt - rd0 != 1) begin
            bad++;
            $display("FAIL single_rd got=%0d want=1", rd_cnt - rd0);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits; int gap, nb, fdp, rd0; bit held, bsy, to;
        logic [7:0] e;
        rd0 = rd_cnt;
        push(8'h00); push(8'hFF); push(8'h3C);
        for (int k = 0; k < 3; k++) begin
            rx(60, bits, gap, nb, held, bsy, fdp, to);
            e = exp_q.pop_front();
            tot++;
            if (to || bits[8:1] !== e || !held || !bsy || fdp != 39) begin
                bad++;
                $display("FAIL b2b_frame k=%0d got=%h want=%h", k,
                         bits[8:1], e);
            end
            if (k > 0) begin
                tot++;
                if (gap != 3 || nb != 1) begin
                    bad++;
                    $display("FAIL b2b_gap k=%0d got=%0d/%0d want=3/1",
                             k, gap, nb);
                end
            end
        end
        tot++;
        if (rd_cnt - rd0 != 3) begin
            bad++;
            $display("FAIL b2b_rd got=%0d want=3", rd_cnt - rd0);
        end
    endtask

    task automatic test_empty_enable;
        logic [9:0] bits; int gap, nb, fdp, rd0; bit held, bsy, to;
        logic [7:0] e;
        bit quiet;
        rd0 = rd_cnt; quiet = 1;
        en = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || rd !== 1'b0) quiet = 0;
        end
        en = 0;
        push(8'h96); push(8'h4B);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx !== 1'b1 || rd !== 1'b0) quiet = 0;
        end
        tot++;
        if (!quiet || rd_cnt != rd0) begin
            bad++;
            $display("FAIL idle_quiet got=%0d reads want=0", rd_cnt - rd0);
        end
        en = 1;
        fork
            rx(20, bits, gap, nb, held, bsy, fdp, to);
            begin
                repeat (20) tick();
                en = 0;
            end
        join
        e = exp_q.pop_front();
        tot++;
        if (to || gap != 2) begin
            bad++;
            $display("FAIL en_latency got=%0d want=2", gap);
        end
        tot++;
        if (bits[8:1] !== e || !held || fdp != 39) begin
            bad++;
            $display("FAIL en_drop_frame got=%h want=%h", bits[8:1], e);
        end
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx !== 1'b1) quiet = 0;
        end
        tot++;
        if (!quiet || rd_cnt - rd0 != 1) begin
            bad++;
            $display("FAIL en_drop_rd got=%0d want=1", rd_cnt - rd0);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits; int gap, nb, fdp, fd0; bit held, bsy, to;
        logic [7:0] e;
        bit seen;
        push(8'h5A); push(8'hE7);
        en = 1;
        rx(20, bits, gap, nb, held, bsy, fdp, to);
        e = exp_q.pop_front();
        tot++;
        if (to || bits[8:1] !== e) begin
            bad++;
            $display("FAIL mid_pre got=%h want=%h", bits[8:1], e);
        end
        fd0 = fd_cnt; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (tx === 1'b0) seen = 1;
        end
        tot++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_start got=no start want=start");
        end
        repeat (17) tick();
        rst = 1;
        tick();
        tot++;
        if ({tx, busy, rd, fd} !== 4'b1000) begin
            bad++;
            $display("FAIL mid_rst got=%b want=1000", {tx, busy, rd, fd});
        end
        rst = 0;
        void'(exp_q.pop_front());
        rx(20, bits, gap, nb, held, bsy, fdp, to);
        e = exp_q.pop_front();
        tot++;
        if (to || bits[8:1] !== e || !held || bits[9] !== 1'b1) begin
            bad++;
            $display("FAIL mid_next got=%h want=%h", bits[8:1], e);
        end
        tot++;
        if (fd_cnt - fd0 != 1) begin
            bad++;
            $display("FAIL mid_fd got=%0d want=1", fd_cnt - fd0);
        end
        en = 0;
    endtask

    task automatic test_cpb1;
        logic [9:0] bits; int fdp; bit seen;
        logic [7:0] e;
        mem1[wp1] = 8'h81;
        wp1 = wp1 + 8'd1;
        exp1_q.push_back(8'h81);
        en1 = 1;
        seen = 0; fdp = -1; bits = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (tx1 === 1'b0) seen = 1;
        end
        en1 = 0;
        if (seen) begin
            for (int i = 0; i < 10; i++) begin
                if (i != 0) tick();
                bits[i] = tx1;
                if (fd1 === 1'b1) fdp = (fdp < 0) ? i : 999;
            end
        end
        e = exp1_q.pop_front();
        tot++;
        if (!seen || bits !== 10'b1100000010) begin
            bad++;
            $display("FAIL cpb1_bits got=%b want=1100000010", bits);
        end
        tot++;
        if (bits[8:1] !== e || fdp != 9) begin
            bad++;
            $display("FAIL cpb1_byte got=%h fd=%0d want=%h fd=9",
                     bits[8:1], fdp, e);
        end
        tick();
        tot++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL cpb1_idle got=%b want=10", {tx1, busy1});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_enable();
        test_reset_mid();
        test_cpb1();
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
